// File: rtl/cache_pkg.sv
// Shared cache definitions: fill engine state encoding and line geometry helpers
// used by the fill engine and the cache way.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        WB_DATA   = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_DATA = 3'd4,
        ALLOC     = 3'd5
    } fill_state_t;

    // Number of memory words held by one cache line.
    function automatic int words_per_block(input int block_size, input int data_width);
        return block_size / (data_width / 8);
    endfunction

    // Width of the word offset inside a line.
    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Fill-side line builder: counts incoming read beats and drops each one into
// its word slot of the line register.
module line_assembler #(
    parameter int DATA_WIDTH   = 32,
    parameter int WORDS        = 8,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        beat_valid,
    input  logic [DATA_WIDTH-1:0]       beat_data,
    output logic                        last_beat,
    output logic [WORDS*DATA_WIDTH-1:0] line
);

    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS - 1);

    logic [OFFSET_WIDTH-1:0] beat_reg;
    logic [DATA_WIDTH-1:0]   word_reg [WORDS];

    assign last_beat = beat_valid && (beat_reg == LAST_BEAT);

    // Beat counter: restarts on each new miss, wraps naturally after the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_reg <= '0;
        end else if (clear) begin
            beat_reg <= '0;
        end else if (beat_valid) begin
            beat_reg <= beat_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            // Each word slot captures the beat whose index matches it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg[gi] <= '0;
                end else if (beat_valid && (beat_reg == OFFSET_WIDTH'(gi))) begin
                    word_reg[gi] <= beat_data;
                end
            end
            assign line[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/line_fill_engine.sv
// Miss handler for one cache set: optional dirty-victim writeback, line fill
// burst from memory, then a single-cycle allocate into the chosen way.
module line_fill_engine
    import cache_pkg::*;
#(
    parameter  int DATA_WIDTH      = 32,
    parameter  int BLOCK_SIZE      = 32,
    parameter  int ADDRESS_WIDTH   = 32,
    localparam int WORDS_PER_BLOCK = words_per_block(BLOCK_SIZE, DATA_WIDTH),
    localparam int OFFSET_WIDTH    = offset_width(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH       = ADDRESS_WIDTH - OFFSET_WIDTH,
    localparam int LINE_W          = WORDS_PER_BLOCK * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic                     victim_valid,
    input  logic                     victim_dirty,
    input  logic [TAG_WIDTH-1:0]     victim_tag,
    input  logic [LINE_W-1:0]        victim_line,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    output logic                     mem_wdata_valid,
    input  logic                     mem_wdata_ready,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     allocate,
    output logic [ADDRESS_WIDTH-1:0] line_address,
    output logic [LINE_W-1:0]        fetched_line,
    output logic                     fill_done
);

    localparam logic [OFFSET_WIDTH-1:0]  LAST_BEAT = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~ADDRESS_WIDTH'((1 << OFFSET_WIDTH) - 1);

    fill_state_t              state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] miss_line_reg;
    logic [TAG_WIDTH-1:0]     victim_tag_reg;
    logic [DATA_WIDTH-1:0]    victim_word_reg [WORDS_PER_BLOCK];
    logic [OFFSET_WIDTH-1:0]  wb_beat_reg;
    logic [ADDRESS_WIDTH-1:0] line_address_reg;
    logic                     accept;
    logic                     wb_advance;
    logic                     fill_beat;
    logic                     fill_last;

    assign accept       = (state_reg == IDLE) && miss_valid;
    assign wb_advance   = (state_reg == WB_DATA) && mem_wdata_ready;
    // Read beats outside the fill burst are ignored, never stalled.
    assign fill_beat    = (state_reg == FILL_DATA) && mem_rdata_valid;
    assign line_address = line_address_reg;

    line_assembler #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WORDS       (WORDS_PER_BLOCK),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_line_assembler (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (accept),
        .beat_valid(fill_beat),
        .beat_data (mem_rdata),
        .last_beat (fill_last),
        .line      (fetched_line)
    );

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Miss context capture plus writeback beat index and published line address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_line_reg    <= '0;
            victim_tag_reg   <= '0;
            wb_beat_reg      <= '0;
            line_address_reg <= '0;
        end else begin
            if (accept) begin
                miss_line_reg  <= miss_addr & LINE_MASK;
                victim_tag_reg <= victim_tag;
                wb_beat_reg    <= '0;
            end else if (wb_advance) begin
                wb_beat_reg    <= wb_beat_reg + 1'b1;
            end
            if (fill_last) begin
                line_address_reg <= miss_line_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_victim
            // Victim words are snapshotted at accept so the way may be overwritten freely.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    victim_word_reg[gi] <= '0;
                end else if (accept) begin
                    victim_word_reg[gi] <= victim_line[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    // Next-state and handshake outputs; outputs are pure functions of held state.
    always_comb begin
        state_next      = state_reg;
        miss_ready      = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_we      = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        allocate        = 1'b0;
        fill_done       = 1'b0;
        case (state_reg)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    state_next = (victim_valid && victim_dirty) ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {victim_tag_reg, {OFFSET_WIDTH{1'b0}}};
                if (mem_req_ready) begin
                    state_next = WB_DATA;
                end
            end
            WB_DATA: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = victim_word_reg[wb_beat_reg];
                if (mem_wdata_ready && (wb_beat_reg == LAST_BEAT)) begin
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = miss_line_reg;
                if (mem_req_ready) begin
                    state_next = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (fill_last) begin
                    state_next = ALLOC;
                end
            end
            ALLOC: begin
                allocate   = 1'b1;
                fill_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine: directed miss scenarios followed by
// randomized misses, with a transaction-level memory/cache reference model.
module tb_line_fill_engine;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 8;
    localparam int OW = 3;
    localparam int TW = AW - OW;
    localparam int LW = N * DW;

    logic          clk             = 1'b0;
    logic          reset_n         = 1'b1;
    logic          miss_valid      = 1'b0;
    logic          miss_ready;
    logic [AW-1:0] miss_addr       = '0;
    logic          victim_valid    = 1'b0;
    logic          victim_dirty    = 1'b0;
    logic [TW-1:0] victim_tag      = '0;
    logic [LW-1:0] victim_line     = '0;
    logic          mem_req_valid;
    logic          mem_req_ready   = 1'b0;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic          mem_wdata_valid;
    logic          mem_wdata_ready = 1'b0;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdata_valid = 1'b0;
    logic [DW-1:0] mem_rdata       = '0;
    logic          allocate;
    logic [AW-1:0] line_address;
    logic [LW-1:0] fetched_line;
    logic          fill_done;

    int            checks        = 0;
    int            fails         = 0;
    int            miss_count    = 0;
    logic [AW-1:0] exp_line_addr = '0;

    line_fill_engine #(
        .DATA_WIDTH   (DW),
        .BLOCK_SIZE   (32),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_addr      (miss_addr),
        .victim_valid   (victim_valid),
        .victim_dirty   (victim_dirty),
        .victim_tag     (victim_tag),
        .victim_line    (victim_line),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata      (mem_wdata),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .allocate       (allocate),
        .line_address   (line_address),
        .fetched_line   (fetched_line),
        .fill_done      (fill_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] seq_line(input logic [DW-1:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < N; i++) l[i*DW +: DW] = base + DW'(i);
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < N; i++) l[i*DW +: DW] = $urandom;
        return l;
    endfunction

    // One miss transaction. The memory side is modelled cycle by cycle on the
    // falling edge: sample engine outputs, then set the responses for the next edge.
    // wmode/rmode: 0 = always ready / back-to-back beats, 1 = alternate cycles, 2 = random.
    task automatic do_miss(input logic [AW-1:0] addr, input logic vv, input logic vd,
                           input logic [TW-1:0] vtag, input logic [LW-1:0] vline,
                           input logic [LW-1:0] rline, input int wmode, input int rmode,
                           input int exp_lat, input bit hold, input bit abort);
        bit            wb_needed, wb_req_done, rd_req_done, rd_active, done, aborted, give, rdy;
        int            wb_idx, rd_idx, cyc, wtoggle;
        logic [AW-1:0] exp_fill_addr, exp_wb_addr;
        wb_needed     = vv && vd;
        wb_req_done   = 0;
        rd_req_done   = 0;
        rd_active     = 0;
        done          = 0;
        aborted       = 0;
        wb_idx        = 0;
        rd_idx        = 0;
        cyc           = 0;
        wtoggle       = 0;
        exp_fill_addr = {addr[AW-1:OW], {OW{1'b0}}};
        exp_wb_addr   = {vtag, {OW{1'b0}}};

        @(negedge clk);
        chk("idle_miss_ready", miss_ready, 1);
        chk("idle_no_alloc", {allocate, fill_done}, 0);
        chk("held_line_address", line_address, exp_line_addr);
        miss_valid   = 1'b1;
        miss_addr    = addr;
        victim_valid = vv;
        victim_dirty = vd;
        victim_tag   = vtag;
        victim_line  = vline;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            miss_addr   = ~addr;
            victim_tag  = ~vtag;
            victim_line = ~vline;
        end else begin
            miss_valid = 1'b0;
        end

        while (!done && cyc < 400) begin
            cyc++;
            rd_active = rd_req_done;
            if (abort && rd_active && rd_idx == 3) begin
                reset_n         = 1'b0;
                miss_valid      = 1'b0;
                mem_rdata_valid = 1'b0;
                mem_req_ready   = 1'b0;
                mem_wdata_ready = 1'b0;
                #1;
                chk("rst_miss_ready", miss_ready, 1);
                chk("rst_ctrl_outputs", {mem_req_valid, mem_req_we, mem_wdata_valid, allocate, fill_done}, 0);
                chk("rst_req_addr", mem_req_addr, 0);
                chk("rst_wdata", mem_wdata, 0);
                chk("rst_line_address", line_address, 0);
                chk("rst_fetched_line", fetched_line, 0);
                exp_line_addr = '0;
                @(negedge clk);
                reset_n = 1'b1;
                done    = 1;
                aborted = 1;
            end else if (allocate) begin
                chk("fill_done_with_alloc", fill_done, 1);
                chk("alloc_after_last_beat", rd_idx, N);
                chk("wb_beat_count", wb_idx, wb_needed ? N : 0);
                chk("line_address", line_address, exp_fill_addr);
                chk("fetched_line", fetched_line, rline);
                if (exp_lat > 0) chk("alloc_latency", cyc, exp_lat);
                mem_rdata_valid = 1'b0;
                mem_req_ready   = 1'b0;
                mem_wdata_ready = 1'b0;
                exp_line_addr   = exp_fill_addr;
                done            = 1;
            end else begin
                chk("busy_miss_ready", miss_ready, 0);
                // read data channel
                mem_rdata_valid = 1'b0;
                mem_rdata       = $urandom;
                if (rd_active) begin
                    if (rd_idx < N) begin
                        if (rmode == 0) give = 1;
                        else if (rmode == 1) give = (cyc % 2 == 0);
                        else give = ($urandom_range(0, 1) == 1);
                        if (give) begin
                            mem_rdata_valid = 1'b1;
                            mem_rdata       = rline[rd_idx*DW +: DW];
                            rd_idx++;
                        end
                    end
                end else begin
                    // stray beats before the fill burst must be ignored
                    mem_rdata_valid = ($urandom_range(0, 1) == 1);
                end
                // request channel
                if (mem_req_valid) begin
                    if (wb_needed && !wb_req_done) begin
                        chk("wb_req_we", mem_req_we, 1);
                        chk("wb_req_addr", mem_req_addr, exp_wb_addr);
                    end else begin
                        chk("rd_req_we", mem_req_we, 0);
                        chk("rd_req_addr", mem_req_addr, exp_fill_addr);
                        chk("wb_done_before_read", wb_idx, wb_needed ? N : 0);
                    end
                    rdy = (wmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
                    mem_req_ready = rdy;
                    if (rdy) begin
                        if (wb_needed && !wb_req_done) wb_req_done = 1;
                        else rd_req_done = 1;
                    end
                end else begin
                    mem_req_ready = ($urandom_range(0, 1) == 1);
                end
                // writeback data channel
                if (mem_wdata_valid) begin
                    chk("wdata_word", mem_wdata, vline[wb_idx*DW +: DW]);
                    if (wmode == 0) rdy = 1;
                    else if (wmode == 1) begin
                        rdy     = (wtoggle == 1);
                        wtoggle = 1 - wtoggle;
                    end else rdy = ($urandom_range(0, 1) == 1);
                    mem_wdata_ready = rdy;
                    if (rdy) wb_idx++;
                end else begin
                    mem_wdata_ready = ($urandom_range(0, 1) == 1);
                end
                @(negedge clk);
            end
        end
        chk("miss_completed", done, 1);
        miss_count++;
        $display("miss %0d addr=%08h dirty=%0d cycles=%0d%s", miss_count, addr,
                 wb_needed, cyc, aborted ? " (reset mid-fill)" : "");
    endtask

    initial begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_miss_ready", miss_ready, 1);
        chk("reset_ctrl_outputs", {mem_req_valid, mem_req_we, mem_wdata_valid, allocate, fill_done}, 0);
        chk("reset_line_address", line_address, 0);
        chk("reset_fetched_line", fetched_line, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // clean victim, ideal memory: allocate 10 edges after accept
        do_miss(32'h0000_1234, 1'b1, 1'b0, TW'(0), rand_line(), seq_line(32'hA0), 0, 0, 10, 0, 0);
        // dirty victim whose writeback address is 0xABC0, then the fill burst
        do_miss(32'h0000_5678, 1'b1, 1'b1, TW'(32'h1578), seq_line(32'hB0), rand_line(), 0, 0, 19, 0, 0);
        // writeback stalls on alternate cycles
        do_miss(32'h0004_0009, 1'b1, 1'b1, TW'(32'h0123_4567), rand_line(), rand_line(), 1, 0, 0, 0, 0);
        // read beats with gaps on every other cycle
        do_miss(32'h8000_00FF, 1'b0, 1'b1, TW'(32'h77), rand_line(), rand_line(), 0, 1, 0, 0, 0);
        // miss_valid held high through a busy dirty miss, then the next miss
        do_miss(32'h0000_2468, 1'b1, 1'b1, TW'(32'h2222), rand_line(), rand_line(), 0, 0, 0, 1, 0);
        do_miss(32'h0000_1357, 1'b0, 1'b0, TW'(0), rand_line(), rand_line(), 0, 0, 10, 0, 0);
        // reset after three read beats, then a clean refill
        do_miss(32'h00CC_0010, 1'b1, 1'b0, TW'(5), rand_line(), rand_line(), 0, 0, 0, 0, 1);
        do_miss(32'h00DD_0020, 1'b1, 1'b0, TW'(6), rand_line(), seq_line(32'hC0), 0, 0, 10, 0, 0);
        // randomized misses with random stalls on every channel
        for (int k = 0; k < 8; k++) begin
            do_miss($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom),
                    rand_line(), rand_line(), 2, 2, 0, 1'($urandom_range(0, 1)), 0);
        end
        miss_valid = 1'b0;
        @(negedge clk);
        chk("final_idle", miss_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
